light_phase_scheduler: RTL

- Central sequencer for the two-approach intersection. Runs the automatic green/yellow/red cycle from a one-second prescaler.
- Extends the current green when traffic waits only on that approach.
- Yields to police override inputs A/B.
- Drives both light outputs and the two-digit BCD countdown displays consumed by the display/counter blocks.

---
 rtl/light_pkg.sv | 20 ++
 rtl/light_bin2bcd.sv | 27 ++
 rtl/light_phase_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// Shared lamp encodings, sequencer state set and BCD digit type.
package light_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    typedef enum logic [2:0] {
        A_GREEN,
        A_YELLOW,
        B_GREEN,
        B_YELLOW,
        MAN_A,
        MAN_B,
        MAN_STOP
    } state_t;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/light_bin2bcd.sv
// Combinational 7-bit binary (0..99) to two-digit BCD converter.
module light_bin2bcd
    import light_pkg::*;
(
    input  logic [6:0] i_bin,
    output bcd_t       o_tens,
    output bcd_t       o_units
);

    logic [6:0] w_rem;
    bcd_t       w_tens;

    // Repeated subtraction of ten; nine steps cover the whole 0..99 range.
    always_comb begin
        w_rem  = i_bin;
        w_tens = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            if (w_rem >= 7'd10) begin
                w_rem  = w_rem - 7'd10;
                w_tens = w_tens + 4'd1;
            end
        end
        o_tens  = w_tens;
        o_units = w_rem[3:0];
    end

endmodule

// File: rtl/light_phase_scheduler.sv
// Two-approach intersection sequencer: timed green/yellow/red cycle with
// traffic-driven green extension, police overrides and BCD countdowns.
module light_phase_scheduler
    import light_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned GREEN_SEC  = 30,
    parameter int unsigned YELLOW_SEC = 3,
    parameter int unsigned EXT_SEC    = 10,
    parameter int unsigned MAX_EXT    = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       A,
    input  logic       B,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    output logic [1:0] A_Light,
    output logic [1:0] B_Light,
    output logic [3:0] A_Time_L,
    output logic [3:0] A_Time_H,
    output logic [3:0] B_Time_L,
    output logic [3:0] B_Time_H
);

    localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [6:0]     GREEN_LD  = 7'(GREEN_SEC);
    localparam logic [6:0]     YELLOW_LD = 7'(YELLOW_SEC);
    localparam logic [6:0]     EXT_LD    = 7'(EXT_SEC);
    localparam logic [2:0]     EXT_LIM   = 3'(MAX_EXT);

    logic [PW-1:0] r_presc;
    state_t        r_state;
    logic [6:0]    r_rem;
    logic [2:0]    r_ext;

    state_t        w_state;
    logic [6:0]    w_rem;
    logic [2:0]    w_ext;
    logic          w_presc_clr;
    logic          w_tick;
    logic [7:0]    w_rem_plus;
    logic [6:0]    w_red_val;
    logic [6:0]    w_a_val;
    logic [6:0]    w_b_val;

    assign w_tick = (r_presc == PRESC_MAX);

    // One-second prescaler; restarts on override release.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_presc <= '0;
        else if (w_presc_clr || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    // Sequencer state, phase remaining time and extension count.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= A_GREEN;
            r_rem   <= GREEN_LD;
            r_ext   <= '0;
        end else begin
            r_state <= w_state;
            r_rem   <= w_rem;
            r_ext   <= w_ext;
        end
    end

    // Next state: overrides every cycle, otherwise tick-driven countdown.
    always_comb begin
        w_state     = r_state;
        w_rem       = r_rem;
        w_ext       = r_ext;
        w_presc_clr = 1'b0;
        if (A || B) begin
            if (A && B)
                w_state = MAN_STOP;
            else if (A)
                w_state = MAN_A;
            else
                w_state = MAN_B;
        end else begin
            case (r_state)
                MAN_A: begin
                    w_state     = A_YELLOW;
                    w_rem       = YELLOW_LD;
                    w_presc_clr = 1'b1;
                end
                MAN_B: begin
                    w_state     = B_YELLOW;
                    w_rem       = YELLOW_LD;
                    w_presc_clr = 1'b1;
                end
                MAN_STOP: begin
                    w_state     = A_GREEN;
                    w_rem       = GREEN_LD;
                    w_ext       = '0;
                    w_presc_clr = 1'b1;
                end
                default: begin
                    if (w_tick) begin
                        if (r_rem != 7'd1) begin
                            w_rem = r_rem - 7'd1;
                        end else begin
                            case (r_state)
                                A_GREEN: begin
                                    if (A_Traffic && !B_Traffic && (r_ext < EXT_LIM)) begin
                                        w_rem = EXT_LD;
                                        w_ext = r_ext + 3'd1;
                                    end else begin
                                        w_state = A_YELLOW;
                                        w_rem   = YELLOW_LD;
                                    end
                                end
                                A_YELLOW: begin
                                    w_state = B_GREEN;
                                    w_rem   = GREEN_LD;
                                    w_ext   = '0;
                                end
                                B_GREEN: begin
                                    if (B_Traffic && !A_Traffic && (r_ext < EXT_LIM)) begin
                                        w_rem = EXT_LD;
                                        w_ext = r_ext + 3'd1;
                                    end else begin
                                        w_state = B_YELLOW;
                                        w_rem   = YELLOW_LD;
                                    end
                                end
                                B_YELLOW: begin
                                    w_state = A_GREEN;
                                    w_rem   = GREEN_LD;
                                    w_ext   = '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign w_rem_plus = {1'b0, r_rem} + 8'(YELLOW_SEC);
    assign w_red_val  = (w_rem_plus > 8'd99) ? 7'd99 : w_rem_plus[6:0];

    // Lamp and countdown decode from registered state.
    always_comb begin
        A_Light = LIGHT_RED;
        B_Light = LIGHT_RED;
        w_a_val = '0;
        w_b_val = '0;
        case (r_state)
            A_GREEN: begin
                A_Light = LIGHT_GREEN;
                w_a_val = r_rem;
                w_b_val = w_red_val;
            end
            A_YELLOW: begin
                A_Light = LIGHT_YELLOW;
                w_a_val = r_rem;
                w_b_val = r_rem;
            end
            B_GREEN: begin
                B_Light = LIGHT_GREEN;
                w_a_val = w_red_val;
                w_b_val = r_rem;
            end
            B_YELLOW: begin
                B_Light = LIGHT_YELLOW;
                w_a_val = r_rem;
                w_b_val = r_rem;
            end
            MAN_A:   A_Light = LIGHT_GREEN;
            MAN_B:   B_Light = LIGHT_GREEN;
            default: ;
        endcase
    end

    light_bin2bcd u_bcd_a (
        .i_bin   (w_a_val),
        .o_tens  (A_Time_H),
        .o_units (A_Time_L)
    );

    light_bin2bcd u_bcd_b (
        .i_bin   (w_b_val),
        .o_tens  (B_Time_H),
        .o_units (B_Time_L)
    );

endmodule
